// File: rtl/weight_column_encoder.sv
// ---------------------------------------------------------------------------
// weight_column_encoder
//   Producer side of the vertical-bit MAC datapath. Latches one vector of
//   VEC_LENGTH signed weights and walks its bit columns LSB first. Each column
//   is described by a compact set of lane selects so the MAC array only has to
//   visit the marked positions.
//
// Ports
//   clk           clock
//   reset         synchronous, active-high
//   w_valid       weight vector valid
//   w_ready       encoder can accept a vector this cycle
//   w_in          VEC_LENGTH signed weights, w_in[i] is weight i
//   col_valid     column control valid (MAC enable)
//   col_ready     MAC consumes the column this cycle
//   act_sel       lane j selects activation index j + act_sel[j] (0..4)
//   act_val       lane j valid
//   is_skip_zero  1: lanes mark set bits, 0: lanes mark clear bits
//   is_msb        current column is the sign column
//   column_idx    current bit column
//   load_accum    first strobe of a vector (MAC restarts accumulation)
//   col_last      final strobe of the current vector
// ---------------------------------------------------------------------------
module weight_column_encoder #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 8,
  parameter int MUX_SEL_WIDTH = 3,
  parameter bit SKIP_ZERO_COL = 1'b1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       w_valid,
  output logic                                       w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]      w_in,
  output logic                                       col_valid,
  input  logic                                       col_ready,
  output logic [3:0][MUX_SEL_WIDTH-1:0]              act_sel,
  output logic [3:0]                                 act_val,
  output logic                                       is_skip_zero,
  output logic                                       is_msb,
  output logic [$clog2(DATA_WIDTH)-1:0]              column_idx,
  output logic                                       load_accum,
  output logic                                       col_last
);

  localparam int COL_W = $clog2(DATA_WIDTH);

  typedef logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] vec_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic [3:0][MUX_SEL_WIDTH-1:0] sel;
    logic [3:0]                    val;
    logic                          skip_zero;
  } lanes_t;

  // Gather bit c of every weight into one column word (bit v = weight v).
  function automatic logic [VEC_LENGTH-1:0] column_bits(input vec_t w,
                                                        input logic [COL_W-1:0] c);
    logic [VEC_LENGTH-1:0] bits;
    bits = '0;
    for (int v = 0; v < VEC_LENGTH; v++) begin
      bits[v] = w[v][c];
    end
    return bits;
  endfunction

  // Set of columns that will produce a strobe. An all-zero vector still
  // needs one strobe so the MAC sees load_accum/col_last; the sign column
  // carries it.
  function automatic logic [DATA_WIDTH-1:0] emit_mask(input vec_t w);
    logic [DATA_WIDTH-1:0] nz;
    nz = '0;
    for (int c = 0; c < DATA_WIDTH; c++) begin
      nz[c] = |column_bits(w, COL_W'(c));
    end
    if (!SKIP_ZERO_COL) begin
      return '1;
    end else if (nz == '0) begin
      return DATA_WIDTH'(1) << (DATA_WIDTH - 1);
    end else begin
      return nz;
    end
  endfunction

  function automatic logic [COL_W-1:0] lowest_column(input logic [DATA_WIDTH-1:0] mask);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int c = DATA_WIDTH - 1; c >= 0; c--) begin
      if (mask[c]) idx = COL_W'(c);
    end
    return idx;
  endfunction

  // Mark the minority bit value (at most 4 positions) and pack the marked
  // positions onto the 4 lanes. The i-th marked position goes to the lowest
  // lane that is both after the previous lane and within reach of the 5:1 mux.
  function automatic lanes_t encode_column(input logic [VEC_LENGTH-1:0] bits);
    lanes_t                r;
    logic [VEC_LENGTH-1:0] marks;
    int                    i;
    int                    lane;
    logic [1:0]            lane_idx;
    r           = '0;
    r.skip_zero = ($countones(bits) <= 4);
    marks       = r.skip_zero ? bits : ~bits;
    i           = 0;
    for (int p = 0; p < VEC_LENGTH; p++) begin
      if (marks[p]) begin
        lane = (p - 4 > i) ? p - 4 : i;
        if (lane < 4) begin
          lane_idx          = 2'(lane);
          r.sel[lane_idx]   = MUX_SEL_WIDTH'(p - lane);
          r.val[lane_idx]   = 1'b1;
        end
        i++;
      end
    end
    return r;
  endfunction

  state_t                        state, state_next;
  vec_t                          weights, weights_next;
  logic [DATA_WIDTH-1:0]         remaining, remaining_next;
  logic                          col_valid_next;
  logic [3:0][MUX_SEL_WIDTH-1:0] act_sel_next;
  logic [3:0]                    act_val_next;
  logic                          is_skip_zero_next;
  logic                          is_msb_next;
  logic [COL_W-1:0]              column_idx_next;
  logic                          load_accum_next;
  logic                          col_last_next;

  logic                          fire;
  logic                          start;
  logic                          advance;
  vec_t                          src;
  logic [DATA_WIDTH-1:0]         mask;
  logic [DATA_WIDTH-1:0]         mask_left;
  logic [COL_W-1:0]              cur;
  lanes_t                        enc;

  // State and registered column outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      weights      <= '0;
      remaining    <= '0;
      col_valid    <= 1'b0;
      act_sel      <= '0;
      act_val      <= '0;
      is_skip_zero <= 1'b0;
      is_msb       <= 1'b0;
      column_idx   <= '0;
      load_accum   <= 1'b0;
      col_last     <= 1'b0;
    end else begin
      state        <= state_next;
      weights      <= weights_next;
      remaining    <= remaining_next;
      col_valid    <= col_valid_next;
      act_sel      <= act_sel_next;
      act_val      <= act_val_next;
      is_skip_zero <= is_skip_zero_next;
      is_msb       <= is_msb_next;
      column_idx   <= column_idx_next;
      load_accum   <= load_accum_next;
      col_last     <= col_last_next;
    end
  end

  // Next-state and next-column computation. 'remaining' holds the columns
  // still owed after the one currently on the outputs, so col_last is known
  // when a column is loaded and the final handshake can accept a new vector.
  always_comb begin
    state_next        = state;
    weights_next      = weights;
    remaining_next    = remaining;
    col_valid_next    = col_valid;
    act_sel_next      = act_sel;
    act_val_next      = act_val;
    is_skip_zero_next = is_skip_zero;
    is_msb_next       = is_msb;
    column_idx_next   = column_idx;
    load_accum_next   = load_accum;
    col_last_next     = col_last;
    w_ready           = 1'b0;
    start             = 1'b0;
    advance           = 1'b0;
    fire              = col_valid & col_ready;

    case (state)
      IDLE: begin
        w_ready = 1'b1;
        start   = w_valid;
      end
      RUN: begin
        if (fire) begin
          if (remaining != '0) begin
            advance = 1'b1;
          end else begin
            w_ready = 1'b1;
            start   = w_valid;
            if (!w_valid) begin
              state_next        = IDLE;
              col_valid_next    = 1'b0;
              act_sel_next      = '0;
              act_val_next      = '0;
              is_skip_zero_next = 1'b0;
              is_msb_next       = 1'b0;
              column_idx_next   = '0;
              load_accum_next   = 1'b0;
              col_last_next     = 1'b0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    src       = start ? w_in : weights;
    mask      = start ? emit_mask(w_in) : remaining;
    cur       = lowest_column(mask);
    mask_left = mask & ~(DATA_WIDTH'(1) << cur);
    enc       = encode_column(column_bits(src, cur));

    if (start || advance) begin
      state_next        = RUN;
      weights_next      = src;
      remaining_next    = mask_left;
      col_valid_next    = 1'b1;
      act_sel_next      = enc.sel;
      act_val_next      = enc.val;
      is_skip_zero_next = enc.skip_zero;
      is_msb_next       = (cur == COL_W'(DATA_WIDTH - 1));
      column_idx_next   = cur;
      load_accum_next   = start;
      col_last_next     = (mask_left == '0);
    end
  end

endmodule
